// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and helpers for the single-port RAM request/grant controller.
package sp_ram_ctrl_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   localparam logic [3:0] BE_ALL = 4'hF;

   function automatic int unsigned num_words(input int unsigned ram_size);
      return ram_size / 4;
   endfunction

endpackage

// File: rtl/sp_ram_init_seq.sv
// Zero-initialisation sequencer: walks every RAM word once after reset.
// Used by sp_ram_port_ctrl only when SP_RAM_ZERO_INIT_EN is defined.
module sp_ram_init_seq
   import sp_ram_ctrl_pkg::*;
#(
   parameter int RAM_SIZE   = 32768,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
   input  logic                  clk,
   input  logic                  rstn_i,
   output logic                  init_req,
   output logic [ADDR_WIDTH-1:0] init_addr,
   output logic                  init_last,
   output logic                  init_done
);

   localparam int              WORD_W    = ADDR_WIDTH - 2;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(num_words(RAM_SIZE) - 1);

   logic [WORD_W-1:0] word_p0;
   logic              done_p0;

   // Word counter advances once per cycle until the last word, then latches done.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         word_p0 <= '0;
         done_p0 <= 1'b0;
      end else if (!done_p0) begin
         if (word_p0 == LAST_WORD) begin
            done_p0 <= 1'b1;
         end else begin
            word_p0 <= word_p0 + 1'b1;
         end
      end
   end

   // Gated by rstn_i so the RAM sees no access while reset is held.
   assign init_req  = ~done_p0 & rstn_i;
   assign init_addr = {word_p0, 2'b00};
   assign init_last = init_req & (word_p0 == LAST_WORD);
   assign init_done = done_p0;

endmodule

// File: rtl/sp_ram_port_ctrl.sv
// Request/grant front-end for a single-port RAM. One access per cycle,
// range check, fixed one-cycle response latency.
// Optional feature macro: SP_RAM_ZERO_INIT_EN (zero the array after reset
// before granting any request).
module sp_ram_port_ctrl
   import sp_ram_ctrl_pkg::*;
#(
   parameter int RAM_SIZE   = 32768,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn_i,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [31:0]           addr_i,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o,
   output logic                  init_done_o,
   output logic                  ram_en_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   output logic                  ram_we_o,
   output logic [3:0]            ram_be_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

   state_e                state_q;
   state_e                state_d;
   logic                  in_range;
   logic                  init_req;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic                  init_last;
   logic                  vld_p1;
   logic                  was_read_p1;
   logic                  was_err_p1;
   logic                  unused_addr_lsb;

`ifdef SP_RAM_ZERO_INIT_EN
   localparam state_e RESET_STATE = INIT;

   sp_ram_init_seq #(
      .RAM_SIZE   (RAM_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_init_seq (
      .clk        (clk),
      .rstn_i     (rstn_i),
      .init_req   (init_req),
      .init_addr  (init_addr),
      .init_last  (init_last),
      .init_done  (init_done_o)
   );
`else
   localparam state_e RESET_STATE = READY;

   assign init_req    = 1'b0;
   assign init_addr   = '0;
   assign init_last   = 1'b0;
   assign init_done_o = 1'b1;
`endif

   // Byte offset within a word is irrelevant to a word-wide RAM.
   assign unused_addr_lsb = ^addr_i[1:0];

   // Any address bit at or above the RAM size (including bits 31..ADDR_WIDTH) is out of range.
   assign in_range = (addr_i < 32'(RAM_SIZE));

   // State register: INIT walks the array (when enabled), READY is held until reset.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, grant and RAM port mux (init sequencer has priority over the core).
   always_comb begin
      state_d     = state_q;
      gnt_o       = 1'b0;
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_wdata_o = wdata_i;
      ram_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};

      case (state_q)
         INIT: begin
            if (init_last) begin
               state_d = READY;
            end
         end
         READY: begin
            // rstn_i gate keeps the grant low while reset is held.
            gnt_o = req_i & rstn_i;
         end
      endcase

      if (init_req) begin
         ram_en_o    = 1'b1;
         ram_we_o    = 1'b1;
         ram_be_o    = BE_ALL;
         ram_wdata_o = '0;
         ram_addr_o  = init_addr;
      end else if (gnt_o && in_range) begin
         ram_en_o = 1'b1;
         ram_we_o = we_i;
         ram_be_o = be_i;
      end
   end

   // ---- stage p1: response flags captured at grant, aligned with RAM read data ----
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         vld_p1      <= 1'b0;
         was_read_p1 <= 1'b0;
         was_err_p1  <= 1'b0;
      end else begin
         vld_p1      <= gnt_o;
         was_read_p1 <= gnt_o & ~we_i;
         was_err_p1  <= gnt_o & ~in_range;
      end
   end

   assign rvalid_o = vld_p1;
   assign err_o    = vld_p1 & was_err_p1;
   assign rdata_o  = (vld_p1 & was_read_p1 & ~was_err_p1) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_sp_ram_port_ctrl.sv
// Self-checking bench for sp_ram_port_ctrl with RAM_SIZE=64 and a behavioural RAM.
// Honours SP_RAM_ZERO_INIT_EN the same way as the design.
module tb_sp_ram_port_ctrl;

   localparam int RAM_SIZE = 64;
   localparam int AW       = 6;
   localparam int NW       = RAM_SIZE / 4;
`ifdef SP_RAM_ZERO_INIT_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn_i;
   logic          req_i;
   logic          gnt_o;
   logic [31:0]   addr_i;
   logic          we_i;
   logic [3:0]    be_i;
   logic [31:0]   wdata_i;
   logic          rvalid_o;
   logic [31:0]   rdata_o;
   logic          err_o;
   logic          init_done_o;
   logic          ram_en_o;
   logic [AW-1:0] ram_addr_o;
   logic [31:0]   ram_wdata_o;
   logic          ram_we_o;
   logic [3:0]    ram_be_o;
   logic [31:0]   ram_rdata_i;

   int checks = 0;
   int errors = 0;

   sp_ram_port_ctrl #(.RAM_SIZE(RAM_SIZE)) dut (
      .clk         (clk),
      .rstn_i      (rstn_i),
      .req_i       (req_i),
      .gnt_o       (gnt_o),
      .addr_i      (addr_i),
      .we_i        (we_i),
      .be_i        (be_i),
      .wdata_i     (wdata_i),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .init_done_o (init_done_o),
      .ram_en_o    (ram_en_o),
      .ram_addr_o  (ram_addr_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_we_o    (ram_we_o),
      .ram_be_o    (ram_be_o),
      .ram_rdata_i (ram_rdata_i)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM: one-cycle read latency, byte-enabled writes.
   logic        preload = 1'b1;
   logic [31:0] ram_mem [NW];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < NW; i++) ram_mem[i] <= 32'hFFFF_FFFF;
      end else if (ram_en_o) begin
         if (ram_we_o) begin
            for (int b = 0; b < 4; b++)
               if (ram_be_o[b]) ram_mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
         end else begin
            ram_rdata_i <= ram_mem[ram_addr_o[AW-1:2]];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Reference model: memory image, init progress and one pending response.
   logic [31:0] ref_mem [NW];
   bit          ref_init = 1'b0;
   bit          m_ready;
   int          init_cnt;
   bit          pend_vld;
   bit          pend_err;
   logic [31:0] pend_data;
   bit          exp_gnt;
   bit          inr;

   always @(negedge clk) begin
      if (!ref_init) begin
         for (int i = 0; i < NW; i++) ref_mem[i] = 32'hFFFF_FFFF;
         ref_init = 1'b1;
      end
      if (!rstn_i) begin
         chk("rst_gnt", gnt_o, 0);
         chk("rst_rvalid", rvalid_o, 0);
         chk("rst_rdata", rdata_o, 0);
         chk("rst_err", err_o, 0);
         chk("rst_ram_en", ram_en_o, 0);
         chk("rst_ram_we", ram_we_o, 0);
         chk("rst_init_done", init_done_o, !INIT_EN);
         init_cnt = 0;
         m_ready  = !INIT_EN;
         pend_vld = 1'b0;
      end else begin
         chk("rvalid", rvalid_o, pend_vld);
         if (pend_vld) begin
            chk("err", err_o, pend_err);
            chk("rdata", rdata_o, pend_data);
         end
         chk("init_done", init_done_o, m_ready);
         exp_gnt = req_i && m_ready;
         chk("gnt", gnt_o, exp_gnt);
         if (!m_ready) begin
            chk("init_en", ram_en_o, 1);
            chk("init_we", ram_we_o, 1);
            chk("init_be", ram_be_o, 4'hF);
            chk("init_wdata", ram_wdata_o, 0);
            chk("init_addr", ram_addr_o, init_cnt * 4);
            ref_mem[init_cnt] = 32'h0;
            init_cnt++;
            if (init_cnt == NW) m_ready = 1'b1;
            pend_vld = 1'b0;
         end else if (exp_gnt) begin
            inr = addr_i < 32'(RAM_SIZE);
            chk("ram_en", ram_en_o, inr);
            if (inr) begin
               chk("ram_addr", ram_addr_o, addr_i & 32'h3C);
               chk("ram_we", ram_we_o, we_i);
               chk("ram_be", ram_be_o, be_i);
               chk("ram_wdata", ram_wdata_o, wdata_i);
            end
            pend_vld  = 1'b1;
            pend_err  = !inr;
            pend_data = (inr && !we_i) ? ref_mem[addr_i[5:2]] : 32'h0;
            if (inr && we_i) ref_mem[addr_i[5:2]] = merge(ref_mem[addr_i[5:2]], wdata_i, be_i);
         end else begin
            chk("idle_en", ram_en_o, 0);
            chk("idle_we", ram_we_o, 0);
            chk("idle_be", ram_be_o, 0);
            pend_vld = 1'b0;
         end
      end
   end

   // One request, then literal checks on grant and the response one cycle later.
   task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
      @(posedge clk); #1;
      req_i = 1'b1; addr_i = a; we_i = we; be_i = be; wdata_i = wd;
      @(negedge clk);
      chk("lit_gnt", gnt_o, 1);
      chk("lit_ram_en", ram_en_o, !exp_err);
      @(posedge clk); #1;
      req_i = 1'b0;
      @(negedge clk);
      chk("lit_rvalid", rvalid_o, 1);
      chk("lit_err", err_o, exp_err);
      chk("lit_rdata", rdata_o, exp_rd);
   endtask

   task automatic wait_init(output int cnt);
      cnt = 0;
      while (!init_done_o && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   initial begin
      int cnt;
      rstn_i = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
      @(posedge clk); #1 preload = 1'b0;
`ifdef SP_RAM_ZERO_INIT_EN
      req_i = 1'b1; addr_i = 32'h3C; we_i = 1'b0;
`endif
      @(posedge clk); #1 rstn_i = 1'b1;
`ifdef SP_RAM_ZERO_INIT_EN
      // Preloaded array is zeroed; the held request is granted only afterwards.
      wait_init(cnt);
      chk("init_cycles", cnt, 16);
      @(negedge clk);
      chk("held_gnt", gnt_o, 1);
      @(posedge clk); #1 req_i = 1'b0;
      @(negedge clk);
      chk("zero_rvalid", rvalid_o, 1);
      chk("zero_rdata", rdata_o, 32'h0);
      // Reset at word 7 restarts the walk from word 0.
      @(posedge clk); #1 rstn_i = 1'b0;
      repeat (2) @(posedge clk); #1 rstn_i = 1'b1;
      repeat (7) @(posedge clk); #1 rstn_i = 1'b0;
      repeat (2) @(posedge clk); #1 rstn_i = 1'b1;
      wait_init(cnt);
      chk("reinit_cycles", cnt, 16);
`endif
      issue(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);
      issue(32'h10, 1'b1, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0);
      issue(32'h13, 1'b0, 4'hF, 32'h0, 32'hDEAD_ABEF, 1'b0);
      issue(32'h40, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
      issue(32'h8000_0010, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++)
         issue(32'(i * 4), 1'b1, 4'hF, 32'h0101_0101 * 32'(i + 1), 32'h0, 1'b0);
      // Back-to-back reads with req held: one grant and one response per cycle, in order.
      @(posedge clk); #1;
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk("b2b_rvalid", rvalid_o, 1);
            chk("b2b_rdata", rdata_o, 32'h0101_0101 * 32'(i));
         end
         if (i < 4) chk("b2b_gnt", gnt_o, 1);
         @(posedge clk); #1;
         if (i < 3) addr_i = 32'((i + 1) * 4);
         else req_i = 1'b0;
      end
      // Random traffic against the reference model.
      repeat (500) begin
         @(posedge clk); #1;
         req_i   = ($urandom_range(0, 3) != 0);
         addr_i  = $urandom_range(0, 95);
         if ($urandom_range(0, 15) == 0) addr_i = addr_i | (32'h1 << $urandom_range(6, 31));
         we_i    = $urandom_range(0, 1);
         be_i    = 4'($urandom_range(0, 15));
         wdata_i = $urandom;
      end
      @(posedge clk); #1 req_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
